// File: rtl/rf_wb_arbiter.sv
// GPR write-port arbiter: pipeline writeback versus a buffered long-latency-unit FIFO.
// Optional forwarding of pending results is enabled by defining WB_BYPASS_EN.
module rf_wb_arbiter #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_waddr,
    input  logic [31:0] pipe_wdata,
    output logic        pipe_stall,
    input  logic        lu_valid,
    input  logic [4:0]  lu_waddr,
    input  logic [31:0] lu_wdata,
    output logic        lu_ready,
    input  logic [4:0]  chk_addr,
    output logic        chk_hit,
    output logic        fwd_valid,
    output logic [31:0] fwd_data,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [CW-1:0] r_wptr;
    logic [CW-1:0] r_rptr;
    logic [4:0]    r_fifo_addr [DEPTH];
    logic [31:0]   r_fifo_data [DEPTH];
    logic [SW-1:0] r_starve;
    logic          r_rf_we;
    logic [4:0]    r_rf_waddr;
    logic [31:0]   r_rf_wdata;

    logic [CW-1:0] w_count;
    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_pipe_req;
    logic          w_force;
    logic          w_gnt_fifo;
    logic          w_gnt_pipe;
    logic [AW-1:0] w_head;
    logic          w_fifo_hit;
    logic          w_rf_hit;

    assign w_count    = r_wptr - r_rptr;
    assign w_empty    = (w_count == '0);
    assign w_full     = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_head     = r_rptr[AW-1:0];

    // Writes to r0 complete their handshake but never reach the FIFO or the port.
    assign w_push     = lu_valid && !w_full && (lu_waddr != 5'd0);
    assign w_pipe_req = pipe_we && (pipe_waddr != 5'd0);

    assign w_force    = !w_empty && (r_starve == SW'(STARVE_MAX));
    assign w_gnt_fifo = !w_empty && (w_force || !w_pipe_req);
    assign w_gnt_pipe = !w_force && w_pipe_req;

    assign pipe_stall = w_force;
    assign lu_ready   = !w_full;
    assign rf_we      = r_rf_we;
    assign rf_waddr   = r_rf_waddr;
    assign rf_wdata   = r_rf_wdata;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wptr[AW-1:0]] <= lu_waddr;
            r_fifo_data[r_wptr[AW-1:0]] <= lu_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + CW'(1);
            end
            if (w_gnt_fifo) begin
                r_rptr <= r_rptr + CW'(1);
            end
        end
    end

    // Counts pipeline grants taken while a FIFO entry waits; saturates to force a drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve <= '0;
        end else if (w_empty || w_gnt_fifo) begin
            r_starve <= '0;
        end else if (w_gnt_pipe && (r_starve != SW'(STARVE_MAX))) begin
            r_starve <= r_starve + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rf_we    <= 1'b0;
            r_rf_waddr <= 5'd0;
            r_rf_wdata <= 32'd0;
        end else begin
            r_rf_we <= w_gnt_fifo || w_gnt_pipe;
            if (w_gnt_fifo) begin
                r_rf_waddr <= r_fifo_addr[w_head];
                r_rf_wdata <= r_fifo_data[w_head];
            end else if (w_gnt_pipe) begin
                r_rf_waddr <= pipe_waddr;
                r_rf_wdata <= pipe_wdata;
            end
        end
    end

    // The head entry counts as pending even on its pop cycle: the RF sees it two edges later.
    always_comb begin
        logic [AW-1:0] idx;
        idx        = '0;
        w_fifo_hit = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = w_head + AW'(k);
            if ((CW'(k) < w_count) && (r_fifo_addr[idx] == chk_addr)) begin
                w_fifo_hit = 1'b1;
            end
        end
    end

    assign w_rf_hit = r_rf_we && (r_rf_waddr == chk_addr);
    assign chk_hit  = (chk_addr != 5'd0) && (w_fifo_hit || w_rf_hit);

`ifdef WB_BYPASS_EN
    logic [31:0] w_fifo_fwd;

    // Walk head to tail so the last match (youngest) wins.
    always_comb begin
        logic [AW-1:0] idx;
        idx        = '0;
        w_fifo_fwd = 32'd0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = w_head + AW'(k);
            if ((CW'(k) < w_count) && (r_fifo_addr[idx] == chk_addr)) begin
                w_fifo_fwd = r_fifo_data[idx];
            end
        end
    end

    assign fwd_valid = chk_hit;
    assign fwd_data  = !chk_hit ? 32'd0 : (w_rf_hit ? r_rf_wdata : w_fifo_fwd);
`else
    assign fwd_valid = 1'b0;
    assign fwd_data  = 32'd0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter (DEPTH=4, STARVE_MAX=8).
module tb_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pipe_we;
    logic [4:0]  pipe_waddr;
    logic [31:0] pipe_wdata;
    logic        pipe_stall;
    logic        lu_valid;
    logic [4:0]  lu_waddr;
    logic [31:0] lu_wdata;
    logic        lu_ready;
    logic [4:0]  chk_addr;
    logic        chk_hit;
    logic        fwd_valid;
    logic [31:0] fwd_data;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int n_checks = 0;
    int n_fail   = 0;

    rf_wb_arbiter #(.DEPTH(4), .STARVE_MAX(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .pipe_we(pipe_we), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
        .pipe_stall(pipe_stall),
        .lu_valid(lu_valid), .lu_waddr(lu_waddr), .lu_wdata(lu_wdata), .lu_ready(lu_ready),
        .chk_addr(chk_addr), .chk_hit(chk_hit), .fwd_valid(fwd_valid), .fwd_data(fwd_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check_rf(input string tag, input logic [4:0] a, input logic [31:0] d);
        check_eq({tag, "_we"}, 32'(rf_we), 32'd1);
        check_eq({tag, "_addr"}, 32'(rf_waddr), 32'(a));
        check_eq({tag, "_data"}, rf_wdata, d);
    endtask

    initial begin
        rst_n = 1'b0; pipe_we = 1'b0; pipe_waddr = 5'd0; pipe_wdata = 32'd0;
        lu_valid = 1'b0; lu_waddr = 5'd0; lu_wdata = 32'd0; chk_addr = 5'd0;
        #12;
        check_eq("rst_rf_we", 32'(rf_we), 32'd0);
        check_eq("rst_rf_waddr", 32'(rf_waddr), 32'd0);
        check_eq("rst_rf_wdata", rf_wdata, 32'd0);
        check_eq("rst_stall", 32'(pipe_stall), 32'd0);
        check_eq("rst_lu_ready", 32'(lu_ready), 32'd1);
        check_eq("rst_chk_hit", 32'(chk_hit), 32'd0);
        check_eq("rst_fwd_valid", 32'(fwd_valid), 32'd0);
        check_eq("rst_fwd_data", fwd_data, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Idle drain with no fall-through
        lu_valid = 1'b1; lu_waddr = 5'd5; lu_wdata = 32'h1234;
        settle();
        check_eq("drain_ready", 32'(lu_ready), 32'd1);
        tick();
        lu_valid = 1'b0; chk_addr = 5'd5;
        settle();
        check_eq("drain_nofall", 32'(rf_we), 32'd0);
        check_eq("drain_hit_fifo", 32'(chk_hit), 32'd1);
        tick();
        check_rf("drain", 5'd5, 32'h1234);
        check_eq("drain_hit_rf", 32'(chk_hit), 32'd1);
        tick();
        check_eq("drain_idle", 32'(rf_we), 32'd0);
        check_eq("drain_hit_clr", 32'(chk_hit), 32'd0);

        // Starvation: 8 pipe grants while r7 waits, then forced drain
        pipe_we = 1'b1; pipe_waddr = 5'd3; pipe_wdata = 32'h30;
        lu_valid = 1'b1; lu_waddr = 5'd7; lu_wdata = 32'hA;
        tick();
        lu_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            settle();
            check_eq("starve_nostall", 32'(pipe_stall), 32'd0);
            tick();
            check_eq("starve_pipe_addr", 32'(rf_waddr), 32'd3);
            check_eq("starve_pipe_we", 32'(rf_we), 32'd1);
        end
        settle();
        check_eq("starve_stall", 32'(pipe_stall), 32'd1);
        tick();
        check_rf("starve_force", 5'd7, 32'hA);
        settle();
        check_eq("starve_unstall", 32'(pipe_stall), 32'd0);
        tick();
        check_rf("starve_resume", 5'd3, 32'h30);

        // Full FIFO, held fifth request, order preserved
        for (int i = 1; i <= 4; i++) begin
            lu_valid = 1'b1; lu_waddr = 5'(i); lu_wdata = 32'h100 + 32'(i);
            tick();
        end
        lu_waddr = 5'd5; lu_wdata = 32'h105; pipe_we = 1'b0;
        settle();
        check_eq("full_not_ready", 32'(lu_ready), 32'd0);
        check_eq("full_no_stall", 32'(pipe_stall), 32'd0);
        tick();
        check_rf("full_pop1", 5'd1, 32'h101);
        settle();
        check_eq("full_ready_again", 32'(lu_ready), 32'd1);
        tick();
        lu_valid = 1'b0;
        check_rf("full_pop2", 5'd2, 32'h102);
        tick();
        check_rf("full_pop3", 5'd3, 32'h103);
        tick();
        check_rf("full_pop4", 5'd4, 32'h104);
        tick();
        check_rf("full_pop5", 5'd5, 32'h105);
        tick();
        check_eq("full_empty", 32'(rf_we), 32'd0);

        // r0 filtering on both requesters
        lu_valid = 1'b1; lu_waddr = 5'd0; lu_wdata = 32'hDEAD;
        settle();
        check_eq("r0_lu_ready", 32'(lu_ready), 32'd1);
        tick();
        lu_valid = 1'b0;
        tick();
        check_eq("r0_lu_dropped", 32'(rf_we), 32'd0);
        pipe_we = 1'b1; pipe_waddr = 5'd0; pipe_wdata = 32'hBEEF;
        tick();
        check_eq("r0_pipe_none", 32'(rf_we), 32'd0);
        lu_valid = 1'b1; lu_waddr = 5'd8; lu_wdata = 32'h88;
        tick();
        lu_valid = 1'b0;
        tick();
        check_rf("r0_pipe_drain", 5'd8, 32'h88);
        pipe_we = 1'b0;
        tick();

        // Hazard check with two pending writes to r9
        pipe_we = 1'b1; pipe_waddr = 5'd3; pipe_wdata = 32'h30;
        lu_valid = 1'b1; lu_waddr = 5'd9; lu_wdata = 32'h55;
        tick();
        lu_wdata = 32'h66;
        tick();
        lu_valid = 1'b0; chk_addr = 5'd9;
        settle();
        check_eq("haz_hit9", 32'(chk_hit), 32'd1);
`ifdef WB_BYPASS_EN
        check_eq("haz_fwd_valid", 32'(fwd_valid), 32'd1);
        check_eq("haz_fwd_young", fwd_data, 32'h66);
`else
        check_eq("haz_fwd_valid", 32'(fwd_valid), 32'd0);
        check_eq("haz_fwd_data", fwd_data, 32'd0);
`endif
        chk_addr = 5'd0;
        settle();
        check_eq("haz_r0", 32'(chk_hit), 32'd0);
        chk_addr = 5'd3;
        settle();
        check_eq("haz_rf_stage", 32'(chk_hit), 32'd1);
`ifdef WB_BYPASS_EN
        check_eq("haz_rf_fwd", fwd_data, 32'h30);
`endif
        chk_addr = 5'd4;
        settle();
        check_eq("haz_miss", 32'(chk_hit), 32'd0);

        // Asynchronous reset with three entries queued
        lu_valid = 1'b1; lu_waddr = 5'd10; lu_wdata = 32'hAA;
        tick();
        lu_valid = 1'b0; chk_addr = 5'd9;
        settle();
        check_eq("pre_rst_hit", 32'(chk_hit), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_rf_we", 32'(rf_we), 32'd0);
        check_eq("arst_rf_waddr", 32'(rf_waddr), 32'd0);
        check_eq("arst_rf_wdata", rf_wdata, 32'd0);
        check_eq("arst_lu_ready", 32'(lu_ready), 32'd1);
        check_eq("arst_stall", 32'(pipe_stall), 32'd0);
        check_eq("arst_chk_hit", 32'(chk_hit), 32'd0);
        check_eq("arst_fwd_valid", 32'(fwd_valid), 32'd0);
        tick();
        rst_n = 1'b1; pipe_we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("post_rst_no_we", 32'(rf_we), 32'd0);
        end
        check_eq("post_rst_hit", 32'(chk_hit), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
